stopwatch_ctrl: RTL and testbench

Control FSM that sequences the stopwatch counter chain (centisecond, second, minute and hour time_counter instances).
- Generates the gated 100 Hz base tick in RUN.
- Issues the one-cycle clear pulse.
- In SET mode, issues per-field add pulses, with hold-to-repeat auto-increment.
- Sits between the debounced button block and the counter chain.

---
 rtl/stopwatch_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: gates the 100 Hz base tick while running, issues the
// one-cycle clear to the counter chain, and produces per-field add pulses
// (with hold-to-repeat) while the user is setting the time.
module stopwatch_ctrl #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int TICK_HZ       = 100,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_up,
    output logic       o_tick,
    output logic       o_clear,
    output logic [2:0] o_add,
    output logic [1:0] o_sel,
    output logic       o_run,
    output logic       o_set_mode
);

    localparam int DIV  = CLK_FREQ / TICK_HZ;
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [PW-1:0] DIV_M1   = PW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] REP_LIM  = HW'(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2,
        ST_SET   = 2'd3
    } state_t;

    // Selected field (0 sec, 1 min, 2 hour) to one-hot add vector.
    function automatic logic [2:0] field_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          rep_q, rep_d;
    logic          up_prev_q, up_prev_d;
    logic [1:0]    sel_q, sel_d;
    logic          tick_q, tick_d;
    logic          clear_q, clear_d;
    logic [2:0]    add_q, add_d;
    logic          run_q, run_d;
    logic          set_mode_q, set_mode_d;

    logic          in_set_s;
    logic          up_rise_s;
    logic          hold_fire_s;
    logic [HW-1:0] hold_inc_s;
    logic [HW-1:0] hold_lim_s;

    // Next-state, prescaler, selection, hold-repeat and output decode.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        sel_d       = sel_q;
        hold_cnt_d  = hold_cnt_q;
        rep_d       = rep_q;
        up_prev_d   = btn_up;
        hold_fire_s = 1'b0;

        case (state_q)
            ST_STOP: begin
                if (btn_clear) begin
                    state_d = ST_CLEAR;
                end else if (btn_run_stop) begin
                    state_d = ST_RUN;
                end else if (btn_mode) begin
                    state_d = ST_SET;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_RUN: begin
                if (btn_run_stop) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CLEAR: begin
                state_d = ST_STOP;
            end
            ST_SET: begin
                if (btn_clear) begin
                    state_d = ST_CLEAR;
                end else if (btn_mode) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_SET;
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase

        // Prescaler only advances in RUN; it keeps its phase across STOP/SET.
        if (state_q == ST_CLEAR) begin
            presc_d = {PW{1'b0}};
        end else if (state_q == ST_RUN) begin
            if (presc_q == DIV_M1) begin
                presc_d = {PW{1'b0}};
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end

        // A stop arriving on the wrap cycle still lets that tick out.
        tick_d = (state_q == ST_RUN) && (presc_q == DIV_M1);

        in_set_s = (state_q == ST_SET);

        // Selection restarts at seconds on every entry into SET.
        if ((state_q != ST_SET) && (state_d == ST_SET)) begin
            sel_d = 2'd0;
        end else if (in_set_s && btn_sel) begin
            if (sel_q >= 2'd2) begin
                sel_d = 2'd0;
            end else begin
                sel_d = sel_q + 2'd1;
            end
        end else begin
            sel_d = sel_q;
        end

        up_rise_s  = in_set_s && btn_up && !up_prev_q;
        hold_inc_s = hold_cnt_q + HW'(1);
        hold_lim_s = rep_q ? REP_LIM : HOLD_LIM;

        // Hold counter: first pulse after HOLD_CYCLES, then every REPEAT_CYCLES.
        if (!in_set_s || !btn_up) begin
            hold_cnt_d = {HW{1'b0}};
            rep_d      = 1'b0;
        end else if (hold_inc_s == hold_lim_s) begin
            hold_fire_s = 1'b1;
            hold_cnt_d  = {HW{1'b0}};
            rep_d       = 1'b1;
        end else begin
            hold_cnt_d = hold_inc_s;
            rep_d      = rep_q;
        end

        // A field change restarts the hold timing; the current add still uses the old field.
        if (in_set_s && btn_sel) begin
            hold_cnt_d = {HW{1'b0}};
            rep_d      = 1'b0;
        end else begin
            hold_cnt_d = hold_cnt_d;
        end

        if ((up_rise_s || hold_fire_s) && (state_d == ST_SET)) begin
            add_d = field_onehot(sel_q);
        end else begin
            add_d = 3'b000;
        end

        clear_d    = (state_d == ST_CLEAR);
        run_d      = (state_d == ST_RUN);
        set_mode_d = (state_d == ST_SET);
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_STOP;
            presc_q    <= {PW{1'b0}};
            hold_cnt_q <= {HW{1'b0}};
            rep_q      <= 1'b0;
            up_prev_q  <= 1'b0;
            sel_q      <= 2'd0;
            tick_q     <= 1'b0;
            clear_q    <= 1'b0;
            add_q      <= 3'b000;
            run_q      <= 1'b0;
            set_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            hold_cnt_q <= hold_cnt_d;
            rep_q      <= rep_d;
            up_prev_q  <= up_prev_d;
            sel_q      <= sel_d;
            tick_q     <= tick_d;
            clear_q    <= clear_d;
            add_q      <= add_d;
            run_q      <= run_d;
            set_mode_q <= set_mode_d;
        end
    end

    assign o_tick     = tick_q;
    assign o_clear    = clear_q;
    assign o_add      = add_q;
    assign o_sel      = sel_q;
    assign o_run      = run_q;
    assign o_set_mode = set_mode_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10, HOLD=20, REPEAT=5.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       btn_mode;
    logic       btn_sel;
    logic       btn_up;
    logic       o_tick;
    logic       o_clear;
    logic [2:0] o_add;
    logic [1:0] o_sel;
    logic       o_run;
    logic       o_set_mode;

    int n_tests = 0;
    int n_fail  = 0;

    stopwatch_ctrl #(
        .CLK_FREQ      (1000),
        .TICK_HZ       (100),
        .HOLD_CYCLES   (20),
        .REPEAT_CYCLES (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
        .btn_mode     (btn_mode),
        .btn_sel      (btn_sel),
        .btn_up       (btn_up),
        .o_tick       (o_tick),
        .o_clear      (o_clear),
        .o_add        (o_add),
        .o_sel        (o_sel),
        .o_run        (o_run),
        .o_set_mode   (o_set_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Steps n cycles, reporting the index of the first tick and the tick count.
    task automatic tick_window(input int n, output int first, output int cnt);
        first = -1;
        cnt   = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (o_tick === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {55'd0, o_tick, o_clear, o_add, o_sel, o_run, o_set_mode};
    endfunction

    int          first;
    int          cnt;
    int          bad_add;
    logic [63:0] add_mask;
    logic [63:0] exp_mask;

    initial begin
        reset        = 1'b0;
        btn_run_stop = 1'b0;
        btn_clear    = 1'b0;
        btn_mode     = 1'b0;
        btn_sel      = 1'b0;
        btn_up       = 1'b0;

        repeat (3) step();
        check("reset_outputs", all_outputs_wrap(), 64'd0);
        reset = 1'b1;
        step();
        check("idle_after_reset", all_outs(), 64'd0);

        // Start running: ticks every 10 cycles, first one 10 cycles in.
        btn_run_stop = 1'b1;
        step();
        btn_run_stop = 1'b0;
        check("run_entered", {63'd0, o_run}, 64'd1);
        tick_window(50, first, cnt);
        check("first_tick_idx", 64'(first), 64'd10);
        check("ticks_in_50", 64'(cnt), 64'd5);

        // Clear is ignored in RUN.
        btn_clear = 1'b1;
        step();
        btn_clear = 1'b0;
        check("clear_ignored_in_run", {62'd0, o_clear, o_run}, 64'd1);
        step();
        step();
        // Stop with the prescaler at 4.
        btn_run_stop = 1'b1;
        step();
        btn_run_stop = 1'b0;
        check("stopped", {63'd0, o_run}, 64'd0);
        tick_window(30, first, cnt);
        check("no_ticks_stopped", 64'(cnt), 64'd0);

        // Resume keeps sub-tick phase: first tick 6 cycles after restart.
        btn_run_stop = 1'b1;
        step();
        btn_run_stop = 1'b0;
        tick_window(10, first, cnt);
        check("resume_first_tick", 64'(first), 64'd6);
        check("resume_tick_count", 64'(cnt), 64'd1);
        btn_run_stop = 1'b1;
        step();
        btn_run_stop = 1'b0;

        // Clear and run_stop together from STOP: clear wins, single pulse.
        btn_clear    = 1'b1;
        btn_run_stop = 1'b1;
        step();
        btn_clear    = 1'b0;
        btn_run_stop = 1'b0;
        check("clear_pulse", {62'd0, o_clear, o_run}, 64'd2);
        step();
        check("clear_one_cycle", {62'd0, o_clear, o_run}, 64'd0);

        // Prescaler was zeroed: full 10-cycle wait, stop on the wrap cycle.
        btn_run_stop = 1'b1;
        step();
        btn_run_stop = 1'b0;
        tick_window(9, first, cnt);
        check("no_tick_before_wrap", 64'(cnt), 64'd0);
        btn_run_stop = 1'b1;
        step();
        btn_run_stop = 1'b0;
        check("tick_on_stop_edge", {62'd0, o_tick, o_run}, 64'd2);
        step();
        check("tick_cleared", {63'd0, o_tick}, 64'd0);

        // SET: two selects then a short press adds to hours.
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        check("set_entry", {60'd0, o_set_mode, o_run, o_sel}, 64'h8);
        btn_sel = 1'b1;
        step();
        btn_sel = 1'b0;
        check("sel_1", {62'd0, o_sel}, 64'd1);
        btn_sel = 1'b1;
        step();
        btn_sel = 1'b0;
        check("sel_2", {62'd0, o_sel}, 64'd2);
        btn_up = 1'b1;
        step();
        btn_up = 1'b0;
        check("add_hour", {61'd0, o_add}, 64'h4);
        step();
        check("add_single", {61'd0, o_add}, 64'h0);
        btn_sel = 1'b1;
        step();
        btn_sel = 1'b0;
        check("sel_wrap", {62'd0, o_sel}, 64'd0);

        // Hold btn_up for 40 cycles on seconds.
        add_mask = 64'd0;
        bad_add  = 0;
        btn_up   = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (o_add === 3'b001) add_mask[i] = 1'b1;
            else if (o_add !== 3'b000) bad_add++;
        end
        btn_up = 1'b0;
        for (int i = 41; i <= 50; i++) begin
            step();
            if (o_add === 3'b001) add_mask[i] = 1'b1;
            else if (o_add !== 3'b000) bad_add++;
        end
        exp_mask     = 64'd0;
        exp_mask[1]  = 1'b1;
        exp_mask[20] = 1'b1;
        exp_mask[25] = 1'b1;
        exp_mask[30] = 1'b1;
        exp_mask[35] = 1'b1;
        exp_mask[40] = 1'b1;
        check("repeat_pattern", add_mask, exp_mask);
        check("repeat_bad_values", 64'(bad_add), 64'd0);

        // Select and press together: add on the old field, then advance.
        btn_sel = 1'b1;
        btn_up  = 1'b1;
        step();
        btn_sel = 1'b0;
        btn_up  = 1'b0;
        check("add_old_sel", {59'd0, o_add, o_sel}, 64'h5);
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        check("leave_set_hold_sel", {61'd0, o_set_mode, o_sel}, 64'd1);
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        check("reenter_sel_zero", {61'd0, o_set_mode, o_sel}, 64'h4);
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;

        // Async reset mid-RUN with prescaler at 7.
        btn_run_stop = 1'b1;
        step();
        btn_run_stop = 1'b0;
        tick_window(7, first, cnt);
        check("run_before_reset", {63'd0, o_run}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outs", all_outs(), 64'd0);
        step();
        reset = 1'b1;
        step();
        check("post_reset_stop", all_outs(), 64'd0);
        btn_run_stop = 1'b1;
        step();
        btn_run_stop = 1'b0;
        tick_window(12, first, cnt);
        check("post_reset_first_tick", 64'(first), 64'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [63:0] all_outputs_wrap();
        return all_outs();
    endfunction

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
